sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter OST_DEPTH, default 4, sets the maximum number of outstanding accepted requests; it SHALL be a power of 2 and at least 2.
REQ-002 clk  in  1  The single clock; all state SHALL update on its rising edge.
REQ-003 resetn  in  1  Reset, synchronous and active-low.
REQ-004 i_req  in  1  Instruction requester request valid.
REQ-005 i_cmd  in  71  Instruction request payload {wr[70], size[69:68], wstrb[67:64], addr[63:32], wdata[31:0]}.
REQ-006 i_addr_ok  out  1  Instruction request accepted this cycle.
REQ-007 i_data_ok  out  1  Instruction response valid this cycle.
REQ-008 i_rdata  out  32  Instruction response data.
REQ-009 d_req  in  1  Data requester request valid.
REQ-010 d_cmd  in  71  Data request payload, same layout as i_cmd.
REQ-011 d_addr_ok  out  1  Data request accepted this cycle.
REQ-012 d_data_ok  out  1  Data response valid this cycle.
REQ-013 d_rdata  out  32  Data response data.
REQ-014 m_req  out  1  Shared-port request valid.
REQ-015 m_cmd  out  71  Shared-port request payload.
REQ-016 m_addr_ok  in  1  Shared port accepted the request.
REQ-017 m_data_ok  in  1  Shared-port response valid; responses return in acceptance order.
REQ-018 m_rdata  in  32  Shared-port response data.

Function
REQ-019 The block SHALL keep an in-order ID FIFO of OST_DEPTH entries, holding 1 bit per entry (0 = inst, 1 = data), with wrapping read/write pointers and an occupancy count of width log2(OST_DEPTH)+1.
REQ-020 sel SHALL be the locked requester when lock=1; otherwise it SHALL come from the arbitration policy over {i_req, d_req}.
REQ-021 m_req SHALL equal req[sel] & ~full; m_cmd SHALL equal cmd[sel], combinationally, with zero added latency.
REQ-022 x_addr_ok SHALL equal m_addr_ok & m_req & (sel==x); the unselected requester SHALL see addr_ok=0.
REQ-023 Handshake (m_req & m_addr_ok) SHALL push sel into the FIFO and clear lock in the same edge.
REQ-024 When m_req=1 and m_addr_ok=0, lock SHALL set to 1 and the lock target SHALL be sel, so the grant stays fixed until acceptance.
REQ-025 If the locked requester drops its req, lock SHALL clear on the next edge.
REQ-026 m_data_ok with a non-empty FIFO SHALL assert x_data_ok for the head ID x only, and SHALL pop the head.
REQ-027 i_rdata and d_rdata SHALL both equal m_rdata at all times.
REQ-028 m_data_ok while the FIFO is empty SHALL be dropped: no data_ok, no pointer change.
REQ-029 When the FIFO is full, m_req SHALL be 0 even if a pop occurs in the same cycle; the freed slot becomes usable the next cycle.
REQ-030 A push and a pop in the same cycle SHALL leave the count unchanged; pointer wrap SHALL be modulo OST_DEPTH.
REQ-031 Write requests SHALL be tracked identically to reads, since the shared port returns data_ok for writes.

Reset
REQ-032 When resetn=0 at an edge: FIFO empty, pointers 0, lock=0, round-robin last-grant=data.
REQ-033 During reset, all outputs SHALL follow from the reset state: m_req reflects the requests (FIFO empty), and x_data_ok=0 except through REQ-026, which cannot fire because the FIFO is empty.
REQ-034 Outstanding responses arriving after a mid-operation reset SHALL be dropped per REQ-028.

Configuration
REQ-035 The macro ARB_RR_EN selects the arbitration policy.
- Defined: round-robin. When both requesters are active, grant goes to the requester not granted at the last handshake. Last-grant updates only on handshake.
- Undefined: fixed priority, data over inst. Last-grant logic SHALL be absent.

Verification
REQ-036 Fixed priority: i_req=d_req=1, m_addr_ok=1 for 2 cycles → d_addr_ok, d_addr_ok, i_addr_ok=0 both cycles. Then m_data_ok ×2 → d_data_ok ×2.
REQ-037 ARB_RR_EN: both requests held, m_addr_ok=1 for 4 cycles → grants d,i,d,i. FIFO holds 1,0,1,0. Four m_data_ok pulses → data_ok alternates d,i,d,i with rdata 0x11,0x22,0x33,0x44 forwarded.
REQ-038 Lock: i_req at cycle 0, m_addr_ok=0 for 3 cycles, d_req from cycle 1 → m_cmd stays i_cmd. m_addr_ok at cycle 3 → i_addr_ok. d granted at cycle 4.
REQ-039 Full: OST_DEPTH=4, 4 accepted, no responses → m_req=0. m_data_ok at cycle N → m_req=1 at N+1, not at N.
REQ-040 Spurious and reset: m_data_ok with the FIFO empty → no data_ok. resetn=0 with 2 outstanding → after reset, count=0 and the later m_data_ok pulses are ignored.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-requester (inst/data) arbiter onto one SRAM-like port, with in-order response routing.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed priority with data over inst.
module sram_req_arbiter #(
    parameter int OST_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [70:0] i_cmd,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [70:0] d_cmd,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic [70:0] m_cmd,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);
    localparam int PW = $clog2(OST_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(OST_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [OST_DEPTH-1:0] id_q;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count;
    logic                 lock, lock_sel;
    logic                 arb_sel, sel, req_sel;
    logic                 full, empty, push, pop, head_id;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head_id = id_q[rd_ptr];

`ifdef ARB_RR_EN
    logic last_grant;

    // Only a real contention flips the grant; a lone requester always wins.
    assign arb_sel = (i_req & d_req) ? ~last_grant : d_req;

    always_ff @(posedge clk) begin
        if (!resetn)   last_grant <= 1'b1;
        else if (push) last_grant <= sel;
    end
`else
    assign arb_sel = d_req;
`endif

    assign sel     = lock ? lock_sel : arb_sel;
    assign req_sel = sel ? d_req : i_req;

    // Full blocks the request even when a pop lands this cycle, keeping m_req off the pop path.
    assign m_req = req_sel & ~full;
    assign m_cmd = sel ? d_cmd : i_cmd;

    assign push = m_req & m_addr_ok;
    assign pop  = m_data_ok & ~empty;

    assign i_addr_ok = push & ~sel;
    assign d_addr_ok = push &  sel;
    assign i_data_ok = pop & ~head_id;
    assign d_data_ok = pop &  head_id;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    // Lock holds exactly while a presented request waits; acceptance or a dropped req releases it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock     <= 1'b0;
            lock_sel <= 1'b0;
        end else begin
            lock <= m_req & ~m_addr_ok;
            if (m_req & ~m_addr_ok) lock_sel <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_q[wr_ptr] <= sel;
                wr_ptr       <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: arbitration, lock, full stall, ordering, spurious and reset drops.
module tb_sram_req_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, d_req, m_addr_ok, m_data_ok;
    logic [70:0] i_cmd, d_cmd;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_req;
    logic [31:0] i_rdata, d_rdata, m_rdata;
    logic [70:0] m_cmd;

    int vec_cnt  = 0;
    int miscmp   = 0;

    localparam logic [70:0] CI = {1'b0, 2'b10, 4'hf, 32'h1000_0000, 32'h0000_0000};
    localparam logic [70:0] CD = {1'b1, 2'b10, 4'hf, 32'h2000_0004, 32'hdead_beef};

    sram_req_arbiter #(.OST_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_cmd(i_cmd), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_cmd(d_cmd), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [70:0] got, input logic [70:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    endtask

    initial begin
        i_cmd = CI; d_cmd = CD; m_rdata = 32'h0;
        resetn = 1'b0; idle();
        tick(); tick();
        chk("rst_mreq", {70'd0, m_req}, 71'd0);
        m_data_ok = 1'b1; #1;
        chk("rst_idok", {70'd0, i_data_ok}, 71'd0);
        chk("rst_ddok", {70'd0, d_data_ok}, 71'd0);
        i_req = 1'b1; #1;
        chk("rst_mreq_follow", {70'd0, m_req}, 71'd1);
        chk("rst_mcmd", m_cmd, CI);
        idle(); tick();
        resetn = 1'b1;

`ifdef ARB_RR_EN
        // A lone inst grant first, so the contended run starts with data.
        i_req = 1'b1; m_addr_ok = 1'b1; #1;
        chk("rr_pre_iaok", {70'd0, i_addr_ok}, 71'd1);
        tick(); idle(); m_data_ok = 1'b1; #1;
        chk("rr_pre_idok", {70'd0, i_data_ok}, 71'd1);
        tick(); idle();
        i_req = 1'b1; d_req = 1'b1; m_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_daok", {70'd0, d_addr_ok}, {70'd0, (k % 2 == 0)});
            chk("rr_iaok", {70'd0, i_addr_ok}, {70'd0, (k % 2 == 1)});
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            m_data_ok = 1'b1; m_rdata = 32'h11 * (k + 1); #1;
            chk("rr_ddok", {70'd0, d_data_ok}, {70'd0, (k % 2 == 0)});
            chk("rr_idok", {70'd0, i_data_ok}, {70'd0, (k % 2 == 1)});
            chk("rr_rdata", {39'd0, d_rdata}, {39'd0, 32'h11 * (k + 1)});
            tick();
        end
        idle();
`else
        i_req = 1'b1; d_req = 1'b1; m_addr_ok = 1'b1; #1;
        chk("fp_daok0", {70'd0, d_addr_ok}, 71'd1);
        chk("fp_iaok0", {70'd0, i_addr_ok}, 71'd0);
        chk("fp_cmd0", m_cmd, CD);
        tick();
        chk("fp_daok1", {70'd0, d_addr_ok}, 71'd1);
        chk("fp_iaok1", {70'd0, i_addr_ok}, 71'd0);
        tick(); idle();
        m_data_ok = 1'b1; m_rdata = 32'h11; #1;
        chk("fp_ddok0", {70'd0, d_data_ok}, 71'd1);
        chk("fp_idok0", {70'd0, i_data_ok}, 71'd0);
        chk("fp_drdata", {39'd0, d_rdata}, {39'd0, 32'h11});
        chk("fp_irdata", {39'd0, i_rdata}, {39'd0, 32'h11});
        tick(); m_rdata = 32'h22; #1;
        chk("fp_ddok1", {70'd0, d_data_ok}, 71'd1);
        tick();
        chk("spur_ddok", {70'd0, d_data_ok}, 71'd0);
        chk("spur_idok", {70'd0, i_data_ok}, 71'd0);
        tick(); idle();
`endif

        // Lock: inst presented with no acceptance, data joins a cycle later.
        i_req = 1'b1; #1;
        chk("lk_mreq0", {70'd0, m_req}, 71'd1);
        chk("lk_cmd0", m_cmd, CI);
        chk("lk_iaok0", {70'd0, i_addr_ok}, 71'd0);
        tick(); d_req = 1'b1; #1;
        chk("lk_cmd1", m_cmd, CI);
        chk("lk_daok1", {70'd0, d_addr_ok}, 71'd0);
        tick();
        chk("lk_cmd2", m_cmd, CI);
        tick(); m_addr_ok = 1'b1; #1;
        chk("lk_iaok3", {70'd0, i_addr_ok}, 71'd1);
        chk("lk_daok3", {70'd0, d_addr_ok}, 71'd0);
        tick();
        chk("lk_daok4", {70'd0, d_addr_ok}, 71'd1);
        chk("lk_iaok4", {70'd0, i_addr_ok}, 71'd0);
        tick(); idle();
        m_data_ok = 1'b1; #1;
        chk("lk_dr_idok", {70'd0, i_data_ok}, 71'd1);
        tick();
        chk("lk_dr_ddok", {70'd0, d_data_ok}, 71'd1);
        tick(); idle();

        // Locked requester withdraws: lock releases on the following edge.
        i_req = 1'b1; #1;
        tick(); i_req = 1'b0; d_req = 1'b1; #1;
        chk("drop_mreq0", {70'd0, m_req}, 71'd0);
        tick();
        chk("drop_mreq1", {70'd0, m_req}, 71'd1);
        chk("drop_cmd", m_cmd, CD);
        idle(); tick();

        // Full: four accepted, a pop does not re-open the port in the same cycle.
        d_req = 1'b1; m_addr_ok = 1'b1;
        repeat (4) tick();
        chk("full_mreq", {70'd0, m_req}, 71'd0);
        chk("full_daok", {70'd0, d_addr_ok}, 71'd0);
        m_data_ok = 1'b1; #1;
        chk("full_popN_mreq", {70'd0, m_req}, 71'd0);
        chk("full_popN_ddok", {70'd0, d_data_ok}, 71'd1);
        tick(); m_data_ok = 1'b0; #1;
        chk("full_N1_mreq", {70'd0, m_req}, 71'd1);
        chk("full_N1_daok", {70'd0, d_addr_ok}, 71'd1);
        tick(); idle();
        m_data_ok = 1'b1; #1;
        chk("full_dr0", {70'd0, d_data_ok}, 71'd1);
        tick();
        chk("full_dr1", {70'd0, d_data_ok}, 71'd1);
        tick(); idle();

        // Reset with two outstanding: their late responses are dropped.
        resetn = 1'b0; tick(); resetn = 1'b1;
        d_req = 1'b1; #1;
        chk("prst_mreq", {70'd0, m_req}, 71'd1);
        d_req = 1'b0; m_data_ok = 1'b1; #1;
        chk("ghost0_d", {70'd0, d_data_ok}, 71'd0);
        chk("ghost0_i", {70'd0, i_data_ok}, 71'd0);
        tick();
        chk("ghost1_d", {70'd0, d_data_ok}, 71'd0);
        chk("ghost1_i", {70'd0, i_data_ok}, 71'd0);
        tick(); idle();

        // Simultaneous push and pop keep the count and the ordering intact.
        i_req = 1'b1; m_addr_ok = 1'b1; #1;
        tick(); i_req = 1'b0; d_req = 1'b1; m_data_ok = 1'b1; #1;
        chk("pp_idok", {70'd0, i_data_ok}, 71'd1);
        chk("pp_daok", {70'd0, d_addr_ok}, 71'd1);
        tick(); d_req = 1'b0; m_addr_ok = 1'b0; #1;
        chk("pp_ddok", {70'd0, d_data_ok}, 71'd1);
        tick();
        chk("pp_empty_d", {70'd0, d_data_ok}, 71'd0);
        chk("pp_empty_i", {70'd0, i_data_ok}, 71'd0);
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end
endmodule
